// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CSUM   = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Header word count is little-endian: low byte arrives first.
    function automatic logic [8*HDR_BYTES-1:0] hdr_count(input logic [7:0] lo, input logic [7:0] hi);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                          s_valid;
    logic [7:0]                    s_data;
    logic                          s_ready;
    logic                          imem_we;
    logic [31:0]                   imem_addr;
    logic [8*BYTES_PER_WORD-1:0]   imem_wd;

    modport master (
        input  s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wd
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wd
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - collects LSB-first stream bytes into one instruction word
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          shift,
    input  logic [7:0]                    data,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic [1:0]                    cnt,
    output logic                          last
);

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            cnt  <= '0;
        end else if (shift) begin
            word <= {data, word[8*BYTES_PER_WORD-1:8]};
            cnt  <= cnt + 2'd1;
        end
    end

    assign last = (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that writes instruction memory and then releases the core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LEN_LO = LEN_LO;
    localparam logic [2:0] S_LEN_HI = LEN_HI;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_WRITE  = WRITE;
    localparam logic [2:0] S_CSUM   = CSUM;
    localparam logic [2:0] S_DONE   = DONE;
    localparam logic [2:0] S_ERROR  = ERROR;

    logic [2:0]               state;
    logic [8*HDR_BYTES-1:0]   len;
    logic [8*HDR_BYTES-1:0]   hdr_len;
    logic [ADDR_W-1:0]        word_idx;
    logic [7:0]               csum;
    logic                     start_ok;
    logic                     shift;
    logic                     last_word;
    logic                     asm_last;
    logic [1:0]               unused_asm_cnt;

    assign bus.s_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                         (state == S_DATA)   || (state == S_CSUM);

    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign shift     = (state == S_DATA) && bus.s_valid;
    assign hdr_len   = hdr_count(len[7:0], bus.s_data);
    assign last_word = (32'(word_idx) == (32'(len) - 32'd1));

    // The assembler's register is the write-data output; it only moves in DATA,
    // so it is stable during the WRITE cycle.
    word_assembler u_asm (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .shift (shift),
        .data  (bus.s_data),
        .word  (bus.imem_wd),
        .cnt   (unused_asm_cnt),
        .last  (asm_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            len           <= '0;
            word_idx      <= '0;
            csum          <= '0;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= '0;
            core_rst      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_LO;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        core_rst <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (bus.s_valid) begin
                        len[7:0] <= bus.s_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (bus.s_valid) begin
                        len      <= hdr_len;
                        word_idx <= '0;
                        csum     <= '0;
                        if ((hdr_len == '0) || (32'(hdr_len) > MAX_WORDS)) begin
                            state <= S_ERROR;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.s_valid) begin
                        csum <= csum + bus.s_data;
                        if (asm_last) begin
                            bus.imem_we   <= 1'b1;
                            bus.imem_addr <= 32'({word_idx, 2'b00});
                            state         <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (last_word) begin
                        state <= S_CSUM;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        state    <= S_DATA;
                    end
                end
                S_CSUM: begin
                    if (bus.s_valid) begin
                        busy <= 1'b0;
                        if (bus.s_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic core_rst, busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (bus.imem_we) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wd);
            check("write_ready_low", 32'(bus.s_ready), 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},  32'(bus.s_ready), 32'd0);
        check({tag, "_we"},       32'(bus.imem_we), 32'd0);
        check({tag, "_addr"},     bus.imem_addr,    32'd0);
        check({tag, "_wd"},       bus.imem_wd,      32'd0);
        check({tag, "_core_rst"}, 32'(core_rst),    32'd0);
        check({tag, "_busy"},     32'(busy),        32'd0);
        check({tag, "_done"},     32'(done),        32'd0);
        check({tag, "_err"},      32'(err),         32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic st);
        int n;
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        start       = st;
        n = 0;
        while (!bus.s_ready && n < 100) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        check("byte_accepted", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic pulse_start();
        wr_addr.delete();
        wr_data.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_image(input logic [31:0] w[$], input logic [7:0] bad,
                              input int gap_max, input int start_at);
        logic [15:0] n16;
        logic [7:0]  sum;
        logic [7:0]  v;
        int          k;
        n16 = 16'(w.size());
        sum = 8'd0;
        k   = 0;
        send_byte(n16[7:0], 0, 1'b0);
        send_byte(n16[15:8], 0, 1'b0);
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                v   = 8'(w[i] >> (8 * b));
                sum = sum + v;
                send_byte(v, int'($urandom_range(gap_max, 0)), k == start_at);
                k++;
            end
        end
        send_byte(sum ^ bad, 0, 1'b0);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] w[$]);
        check({tag, "_count"}, 32'(wr_addr.size()), 32'(w.size()));
        if (wr_addr.size() == w.size()) begin
            foreach (w[i]) begin
                check({tag, "_addr"}, wr_addr[i], 32'(i * 4));
                check({tag, "_data"}, wr_data[i], w[i]);
            end
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check({tag, "_done"},     32'(done),     32'(d));
        check({tag, "_err"},      32'(err),      32'(e));
        check({tag, "_core_rst"}, 32'(core_rst), 32'(c));
        check({tag, "_busy"},     32'(busy),     32'd0);
    endtask

    logic [7:0]  img1[7];
    logic [31:0] w3[$];
    logic [31:0] w2[$];
    logic [31:0] wmax[$];

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        img1 = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h68};
        w3   = '{32'h11223344, 32'hA5A50F0F, 32'hDEADBEEF};
        w2   = '{32'hCAFEF00D, 32'h0000_0073};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        bus.s_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ignores_valid", 32'(bus.s_ready), 32'd0);
        bus.s_valid = 1'b0;

        // Single-word image from literal bytes.
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_core_rst", 32'(core_rst), 32'd0);
        check("start_ready", 32'(bus.s_ready), 32'd1);
        foreach (img1[i]) send_byte(img1[i], 0, 1'b0);
        check_writes("n1", '{32'h00500513});
        check_status("n1", 1'b1, 1'b0, 1'b1);

        // Restart from DONE drops the core back into reset immediately.
        pulse_start();
        check("restart_core_rst", 32'(core_rst), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        send_image(w3, 8'h00, 3, 6);
        check_writes("n3", w3);
        check_status("n3", 1'b1, 1'b0, 1'b1);

        // Bad checksum: write still lands, core stays held.
        pulse_start();
        img1[6] = 8'h69;
        foreach (img1[i]) send_byte(img1[i], 0, 1'b0);
        check_writes("badcsum", '{32'h00500513});
        check_status("badcsum", 1'b0, 1'b1, 1'b0);

        // Zero-length header.
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        check_status("n0", 1'b0, 1'b1, 1'b0);
        check("n0_ready", 32'(bus.s_ready), 32'd0);
        check("n0_writes", 32'(wr_addr.size()), 32'd0);

        // One word beyond capacity.
        pulse_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h04, 0, 1'b0);
        check_status("n1025", 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("n1025_ready", 32'(bus.s_ready), 32'd0);
        check("n1025_writes", 32'(wr_addr.size()), 32'd0);

        // Reset mid-way through the second word.
        pulse_start();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        for (int b = 0; b < 4; b++) send_byte(8'(w2[0] >> (8 * b)), 0, 1'b0);
        send_byte(8'h73, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        #1 rst = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        check("midrst_writes", 32'(wr_addr.size()), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
        send_image(w2, 8'h00, 1, -1);
        check_writes("recover", w2);
        check_status("recover", 1'b1, 1'b0, 1'b1);

        // Full-capacity image.
        for (int i = 0; i < 1024; i++) wmax.push_back({16'(i), ~16'(i)});
        pulse_start();
        send_image(wmax, 8'h00, 0, -1);
        check_writes("nmax", wmax);
        if (wr_addr.size() > 0) check("nmax_last_addr", wr_addr[wr_addr.size()-1], 32'h0000_0FFC);
        check_status("nmax", 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
